// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
//
// Turns stereo samples from the effect chain into an I2S stream for the
// output codec. One stereo sample is taken per frame through a one-entry
// valid/ready holding register. BCLK and LRCLK are divided down from the
// system clock, and data goes out MSB-first one BCLK after each LRCLK edge.
//
// Parameters:
//   CLK_DIV       system clocks per BCLK half-period (>= 1)
//   SAMPLE_WIDTH  bits sent per channel, taken from the top of each 32-bit
//                 sample (1..31); lower bits are truncated
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   in_L, in_R    signed 32-bit left/right samples
//   sample_valid  in_L/in_R are valid this cycle
//   sample_ready  holding register is empty
//   bclk          bit clock
//   lrclk         word select (0 = left, 1 = right)
//   sdata         serial data, changes only when bclk falls
//   frame_start   one-cycle pulse at each frame boundary
//   underflow     one-cycle pulse at a boundary that found no sample waiting
//
// Build option:
//   I2S_TX_REPEAT_EN  when defined, an underflow frame repeats the last
//                     transmitted sample pair; otherwise it sends silence.
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_L,
  input  logic [31:0] in_R,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underflow
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       SW6      = 6'(SAMPLE_WIDTH);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             frame_start_q, frame_start_d;
  logic             underflow_q, underflow_d;
  logic             hold_full_q, hold_full_d;
  logic [31:0]      hold_l_q, hold_l_d;
  logic [31:0]      hold_r_q, hold_r_d;
  logic [31:0]      tx_l_q, tx_l_d;
  logic [31:0]      tx_r_q, tx_r_d;

  logic       div_tc;
  logic       fall_evt;
  logic       boundary;
  logic       accept;
  logic [5:0] next_slot;
  logic [4:0] slot_idx;
  logic [4:0] bit_pos;
  logic       slot_active;
  logic       slot_bit;

  // State register: every flop takes its reset value in the cycle after
  // reset is sampled, which abandons any partial frame. bit_cnt parks at 63
  // so that the first falling event after release is a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= 6'd63;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      tx_l_q        <= '0;
      tx_r_q        <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      tx_l_q        <= tx_l_d;
      tx_r_q        <= tx_r_d;
    end
  end

  // Slot decode for the slot being entered on a falling event. Within each
  // half, slot s (1..SAMPLE_WIDTH) carries bit 32-s of that channel; slot 0
  // of each half and everything past SAMPLE_WIDTH are zero. The bit position
  // 32-s is formed as a 5-bit negation of the slot index.
  always_comb begin
    next_slot   = bit_cnt_q + 6'd1;
    slot_idx    = next_slot[4:0];
    bit_pos     = 5'd0 - slot_idx;
    slot_active = (slot_idx != 5'd0) && ({1'b0, slot_idx} <= SW6);
    slot_bit    = 1'b0;
    if (slot_active) begin
      slot_bit = next_slot[5] ? tx_r_q[bit_pos] : tx_l_q[bit_pos];
    end
  end

  // Next-state logic: clock divider, slot counter, frame boundary handling
  // and the upstream handshake. The transmit registers hold the whole pair
  // for the frame and are indexed by slot, so after a frame they still hold
  // the last transmitted pair, which the repeat build relies on.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    bclk_d        = bclk_q;
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    tx_l_d        = tx_l_q;
    tx_r_d        = tx_r_q;

    div_tc   = (div_cnt_q == DIV_LAST);
    fall_evt = div_tc && bclk_q;
    boundary = fall_evt && (bit_cnt_q == 6'd63);
    accept   = sample_valid && !hold_full_q;

    if (div_tc) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (fall_evt) begin
      bit_cnt_d = next_slot;
      lrclk_d   = next_slot[5];
      sdata_d   = slot_bit;
    end

    if (boundary) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        tx_l_d      = hold_l_q;
        tx_r_d      = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underflow_d = 1'b1;
`ifdef I2S_TX_REPEAT_EN
        tx_l_d = tx_l_q;
        tx_r_d = tx_r_q;
`else
        tx_l_d = '0;
        tx_r_d = '0;
`endif
      end
    end

    // Acceptance is only possible while empty, so it never collides with a
    // boundary that drains the register. A sample accepted on an empty
    // boundary waits for the next frame.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = in_L;
      hold_r_d    = in_R;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underflow    = underflow_q;

endmodule
